// File: rtl/tick_period_meter.sv
// Measures the clk_in-cycle interval between rising edges of tick_in and reports it via valid/ack.
// Optional min/max period tracking is enabled by defining TICK_PERIOD_METER_MINMAX_EN.
module tick_period_meter #(
   parameter int CNT_W       = 26,
   parameter int TIMEOUT     = 50000000,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             tick_in,
   input  logic             period_ack,
`ifdef TICK_PERIOD_METER_MINMAX_EN
   input  logic             minmax_clr,
   output logic [CNT_W-1:0] min_period,
   output logic [CNT_W-1:0] max_period,
`endif
   output logic [CNT_W-1:0] period_out,
   output logic             period_valid,
   output logic             locked,
   output logic             timeout,
   output logic             overrun
);

   typedef enum logic [1:0] {IDLE, MEASURE, TIMED_OUT} state_t;

   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;
   logic                   tick_edge;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   result;
   logic                   to_timeout;
   logic                   from_timeout;

   // tick_in may be asynchronous; SYNC_STAGES must be at least 2
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], tick_in};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign tick_edge = sync_q[SYNC_STAGES-1] & ~hist_q;

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // An edge on the cycle cnt reaches TIMEOUT takes priority over declaring timeout
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      result       = 1'b0;
      to_timeout   = 1'b0;
      from_timeout = 1'b0;
      case (state_q)
         IDLE: begin
            if (tick_edge) begin
               cnt_d   = CNT_W'(1);
               state_d = MEASURE;
            end
         end
         MEASURE: begin
            if (tick_edge) begin
               result = 1'b1;
               cnt_d  = CNT_W'(1);
            end else if (cnt_q == TIMEOUT_CNT) begin
               to_timeout = 1'b1;
               cnt_d      = '0;
               state_d    = TIMED_OUT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         TIMED_OUT: begin
            cnt_d = '0;
            if (tick_edge) begin
               from_timeout = 1'b1;
               cnt_d        = CNT_W'(1);
               state_d      = MEASURE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         period_out   <= '0;
         period_valid <= 1'b0;
         locked       <= 1'b0;
         timeout      <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         if (result) begin
            period_out   <= cnt_q;
            period_valid <= 1'b1;
            locked       <= 1'b1;
            if (period_valid && !period_ack) begin
               overrun <= 1'b1;
            end
         end else if (period_ack) begin
            period_valid <= 1'b0;
         end
         if (to_timeout) begin
            timeout <= 1'b1;
            locked  <= 1'b0;
         end else if (from_timeout) begin
            timeout <= 1'b0;
         end
      end
   end

`ifdef TICK_PERIOD_METER_MINMAX_EN
   // A result arriving together with a clear seeds both extremes with that result
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         min_period <= '1;
         max_period <= '0;
      end else if (minmax_clr) begin
         min_period <= result ? cnt_q : '1;
         max_period <= result ? cnt_q : '0;
      end else if (result) begin
         if (cnt_q < min_period) begin
            min_period <= cnt_q;
         end
         if (cnt_q > max_period) begin
            max_period <= cnt_q;
         end
      end
   end
`endif

endmodule

// File: tb/tb_tick_period_meter.sv
// Self-checking bench for tick_period_meter: directed scenarios plus random tick periods,
// compared every cycle against an edge-timestamp reference model.
module tb_tick_period_meter;

   localparam int CNT_W   = 12;
   localparam int TIMEOUT = 200;
   localparam int SYNC    = 2;

   logic             clk_in = 1'b0;
   logic             rst_n  = 1'b1;
   logic             tick_in = 1'b0;
   logic             period_ack = 1'b0;
   logic [CNT_W-1:0] period_out;
   logic             period_valid;
   logic             locked;
   logic             timeout;
   logic             overrun;
`ifdef TICK_PERIOD_METER_MINMAX_EN
   logic             minmax_clr = 1'b0;
   logic [CNT_W-1:0] min_period;
   logic [CNT_W-1:0] max_period;
   logic [CNT_W-1:0] m_min;
   logic [CNT_W-1:0] m_max;
`endif

   int checks = 0;
   int errors = 0;
   int ack_pct = 0;
   bit force_ack = 1'b0;

   // Reference model state: edges are timestamped, periods are timestamp differences
   bit               samp[$];
   int               cyc = 0;
   int               m_ref = 0;
   bit               m_have_ref, m_tmo, m_valid, m_locked, m_overrun;
   logic [CNT_W-1:0] m_period;

   tick_period_meter #(
      .CNT_W(CNT_W),
      .TIMEOUT(TIMEOUT),
      .SYNC_STAGES(SYNC)
   ) dut (
      .clk_in(clk_in),
      .rst_n(rst_n),
      .tick_in(tick_in),
      .period_ack(period_ack),
`ifdef TICK_PERIOD_METER_MINMAX_EN
      .minmax_clr(minmax_clr),
      .min_period(min_period),
      .max_period(max_period),
`endif
      .period_out(period_out),
      .period_valid(period_valid),
      .locked(locked),
      .timeout(timeout),
      .overrun(overrun)
   );

   always #5 clk_in = ~clk_in;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Rising edges become visible to the meter SYNC cycles after sampling
   initial forever begin
      @(posedge clk_in or negedge rst_n);
      if (!rst_n) begin
         samp.delete();
         for (int i = 0; i < SYNC + 2; i++) samp.push_back(1'b0);
         m_have_ref = 0; m_tmo = 0; m_valid = 0; m_locked = 0; m_overrun = 0;
         m_period = '0;
`ifdef TICK_PERIOD_METER_MINMAX_EN
         m_min = '1; m_max = '0;
`endif
      end else begin
         bit got;
         bit edge_seen;
         int res;
         cyc++;
         samp.push_front(tick_in);
         edge_seen = samp[SYNC] && !samp[SYNC+1];
         void'(samp.pop_back());
         got = 0;
         res = 0;
         if (edge_seen) begin
            if (m_have_ref && !m_tmo) begin
               got = 1;
               res = cyc - m_ref;
            end
            m_have_ref = 1;
            m_tmo = 0;
            m_ref = cyc;
         end else if (m_have_ref && !m_tmo && (cyc - m_ref) == TIMEOUT) begin
            m_tmo = 1;
            m_locked = 0;
         end
         if (got) begin
            if (m_valid && !period_ack) m_overrun = 1;
            m_period = CNT_W'(res);
            m_valid = 1;
            m_locked = 1;
         end else if (period_ack) begin
            m_valid = 0;
         end
`ifdef TICK_PERIOD_METER_MINMAX_EN
         if (minmax_clr) begin
            m_min = got ? CNT_W'(res) : '1;
            m_max = got ? CNT_W'(res) : '0;
         end else if (got) begin
            if (CNT_W'(res) < m_min) m_min = CNT_W'(res);
            if (CNT_W'(res) > m_max) m_max = CNT_W'(res);
         end
`endif
      end
   end

   initial forever begin
      @(posedge clk_in);
      #1;
      checkOutput("period_out", 32'(period_out), 32'(m_period));
      checkOutput("period_valid", 32'(period_valid), 32'(m_valid));
      checkOutput("locked", 32'(locked), 32'(m_locked));
      checkOutput("timeout", 32'(timeout), 32'(m_tmo));
      checkOutput("overrun", 32'(overrun), 32'(m_overrun));
`ifdef TICK_PERIOD_METER_MINMAX_EN
      checkOutput("min_period", 32'(min_period), 32'(m_min));
      checkOutput("max_period", 32'(max_period), 32'(m_max));
`endif
   end

   initial forever begin
      @(negedge clk_in);
      #1;
      period_ack = force_ack || ($urandom_range(0, 99) < ack_pct);
   end

   task automatic idleCycles(input int n);
      repeat (n) @(negedge clk_in);
   endtask

   task automatic tickHigh(input int n);
      tick_in = 1'b1;
      idleCycles(n);
      tick_in = 1'b0;
   endtask

   // One full tick period: rising edge now, next rising edge starts the following call
   task automatic applyStimulus(input int period);
      int hi;
      hi = (period >= 12) ? 6 : period / 2;
      tickHigh(hi);
      idleCycles(period - hi);
   endtask

   task automatic applyReset();
      rst_n = 1'b0;
      idleCycles(3);
      rst_n = 1'b1;
   endtask

   initial begin
      #1 rst_n = 1'b0;
      @(negedge clk_in);
      idleCycles(2);
      checkOutput("rst_period_out", 32'(period_out), 32'd0);
      checkOutput("rst_valid", 32'(period_valid), 32'd0);
      checkOutput("rst_locked", 32'(locked), 32'd0);
      checkOutput("rst_timeout", 32'(timeout), 32'd0);
      checkOutput("rst_overrun", 32'(overrun), 32'd0);
      rst_n = 1'b1;

      $display("[TB] steady 100-cycle ticks with prompt ack");
      ack_pct = 40;
      applyStimulus(100);
      checkOutput("first_edge_valid", 32'(period_valid), 32'd0);
      checkOutput("first_edge_locked", 32'(locked), 32'd0);
      repeat (3) applyStimulus(100);
      tickHigh(6);
      checkOutput("steady_period", 32'(period_out), 32'd100);
      checkOutput("steady_locked", 32'(locked), 32'd1);
      checkOutput("steady_overrun", 32'(overrun), 32'd0);
      ack_pct = 0;
      idleCycles(94);

      $display("[TB] periods 37 and 64 without ack");
      applyStimulus(37);
      applyStimulus(64);
      tickHigh(6);
      checkOutput("ovr_valid", 32'(period_valid), 32'd1);
      checkOutput("ovr_period", 32'(period_out), 32'd64);
      checkOutput("ovr_overrun", 32'(overrun), 32'd1);
      idleCycles(30);

      $display("[TB] ack on the same cycle as a new result");
      applyReset();
      applyStimulus(40);
      applyStimulus(50);
      tick_in = 1'b1;
      idleCycles(2);
      force_ack = 1'b1;
      idleCycles(1);
      force_ack = 1'b0;
      idleCycles(3);
      tick_in = 1'b0;
      checkOutput("sameack_valid", 32'(period_valid), 32'd1);
      checkOutput("sameack_period", 32'(period_out), 32'd50);
      checkOutput("sameack_overrun", 32'(overrun), 32'd0);
      idleCycles(20);

      $display("[TB] tick loss and recovery");
      applyReset();
      ack_pct = 100;
      applyStimulus(80);
      applyStimulus(80);
      tickHigh(6);
      idleCycles(190);
      checkOutput("pre_tmo_timeout", 32'(timeout), 32'd0);
      checkOutput("pre_tmo_locked", 32'(locked), 32'd1);
      idleCycles(20);
      checkOutput("tmo_timeout", 32'(timeout), 32'd1);
      checkOutput("tmo_locked", 32'(locked), 32'd0);
      ack_pct = 0;
      tickHigh(6);
      checkOutput("resume_ref_valid", 32'(period_valid), 32'd0);
      checkOutput("resume_ref_timeout", 32'(timeout), 32'd0);
      idleCycles(74);
      tickHigh(6);
      checkOutput("resume_period", 32'(period_out), 32'd80);
      checkOutput("resume_valid", 32'(period_valid), 32'd1);
      checkOutput("resume_timeout", 32'(timeout), 32'd0);
      checkOutput("resume_locked", 32'(locked), 32'd1);
      idleCycles(74);

      $display("[TB] edge exactly at the timeout count");
      ack_pct = 100;
      applyStimulus(TIMEOUT);
      ack_pct = 0;
      tickHigh(6);
      checkOutput("edge_at_limit_period", 32'(period_out), 32'(TIMEOUT));
      checkOutput("edge_at_limit_timeout", 32'(timeout), 32'd0);
      idleCycles(TIMEOUT + 1 - 6);
      tickHigh(6);
      checkOutput("past_limit_period", 32'(period_out), 32'(TIMEOUT));
      checkOutput("past_limit_timeout", 32'(timeout), 32'd0);
      idleCycles(50);

`ifdef TICK_PERIOD_METER_MINMAX_EN
      $display("[TB] min/max tracking");
      applyReset();
      ack_pct = 50;
      applyStimulus(90);
      applyStimulus(40);
      applyStimulus(120);
      tickHigh(6);
      checkOutput("mm_min", 32'(min_period), 32'd40);
      checkOutput("mm_max", 32'(max_period), 32'd120);
      minmax_clr = 1'b1;
      idleCycles(1);
      minmax_clr = 1'b0;
      idleCycles(63);
      tickHigh(6);
      checkOutput("mm_clr_min", 32'(min_period), 32'd70);
      checkOutput("mm_clr_max", 32'(max_period), 32'd70);
      idleCycles(30);
`endif

      $display("[TB] reset in the middle of a period");
      ack_pct = 0;
      rst_n = 1'b0;
      idleCycles(1);
      checkOutput("midrst_period", 32'(period_out), 32'd0);
      checkOutput("midrst_valid", 32'(period_valid), 32'd0);
      checkOutput("midrst_locked", 32'(locked), 32'd0);
      checkOutput("midrst_timeout", 32'(timeout), 32'd0);
      checkOutput("midrst_overrun", 32'(overrun), 32'd0);
      idleCycles(1);
      rst_n = 1'b1;
      tickHigh(6);
      checkOutput("post_rst_ref_valid", 32'(period_valid), 32'd0);
      checkOutput("post_rst_ref_locked", 32'(locked), 32'd0);
      idleCycles(54);
      tickHigh(6);
      checkOutput("post_rst_period", 32'(period_out), 32'd60);
      idleCycles(20);

      $display("[TB] random periods and ack rates");
      for (int i = 0; i < 40; i++) begin
         int p;
         ack_pct = $urandom_range(0, 100);
         case ($urandom_range(0, 7))
            0:       p = 2 + $urandom_range(0, 3);
            1:       p = TIMEOUT - 1 + $urandom_range(0, 2);
            default: p = $urandom_range(2, TIMEOUT + 30);
         endcase
`ifdef TICK_PERIOD_METER_MINMAX_EN
         if ($urandom_range(0, 9) == 0) begin
            minmax_clr = 1'b1;
            idleCycles(1);
            minmax_clr = 1'b0;
         end
`endif
         applyStimulus(p);
      end
      idleCycles(TIMEOUT + 10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
